as_lut_lookup_req: RTL and testbench
====================================

AS_LUT_LOOKUP_REQ -- requirements
Module: as_lut_lookup_req

Interface
REQ-001 SHALL have parameter NUM_OUTPUT_QUEUES, default 8, giving the output-port bitmap width.
REQ-002 SHALL have parameter NUM_IQ_BITS, default 3, giving the source-port index width.
REQ-003 SHALL have parameter IOQ_CTRL, default 8'hFF, giving the in_ctrl value that marks the IOQ module-header word.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-005 SHALL have in_data  in  64  snooped datapath word.
REQ-006 SHALL have in_ctrl  in  8  snooped control byte; 0 means packet payload.
REQ-007 SHALL have in_wr  in  1  word valid; the block applies no backpressure.
REQ-008 SHALL have dst_mac  out  48; src_mac  out  48; src_ip  out  32; dst_ip  out  32 as the latched lookup key.
REQ-009 SHALL have src_port  out  NUM_IQ_BITS  latched ingress port.
REQ-010 SHALL have lookup_req  out  1  and lookup_ack  in  1  as the LUT request handshake.
REQ-011 SHALL have dst_ports  in  NUM_OUTPUT_QUEUES  LUT result, valid in the cycle lookup_ack first rises.
REQ-012 SHALL have result_ports  out  NUM_OUTPUT_QUEUES; result_vld  out  1; result_ack  in  1  as the consumer handshake.
REQ-013 SHALL have skipped_pkt  out  1 and short_pkt  out  1, each a one-cycle status pulse.

Function
REQ-014 SHALL implement five states: IDLE, PARSE, REQ, WAIT_ACK_LOW, HOLD.
REQ-015 In IDLE, in_wr with in_ctrl==IOQ_CTRL SHALL latch src_port=in_data[16+NUM_IQ_BITS-1:16], clear word_cnt (3 bits), and move to PARSE.
REQ-016 In PARSE, each in_wr with in_ctrl==0 SHALL increment word_cnt; the count saturates at 7.
REQ-017 Word 0 SHALL set dst_mac=in_data[63:16] and src_mac[47:32]=in_data[15:0].
REQ-018 Word 1 SHALL set src_mac[31:0]=in_data[63:32].
REQ-019 Word 3 SHALL set src_ip=in_data[47:16] and dst_ip[31:16]=in_data[15:0].
REQ-020 Word 4 SHALL set dst_ip[15:0]=in_data[63:48], and the next state SHALL be REQ.
REQ-021 Fields SHALL be captured raw; the ethertype is not checked.
REQ-022 In PARSE, an in_wr with in_ctrl!=0 before word 4 (short packet) SHALL pulse short_pkt for one cycle and return to IDLE with no request issued.
REQ-023 In REQ, lookup_req SHALL be 1 and the key outputs SHALL be held stable.
REQ-024 When lookup_ack==1 in REQ, the block SHALL latch result_ports=dst_ports, deassert lookup_req in the next cycle, and move to WAIT_ACK_LOW.
REQ-025 In WAIT_ACK_LOW, the block SHALL wait for lookup_ack==0, then move to HOLD with result_vld=1.
REQ-026 In HOLD, result_vld and result_ports SHALL be held until result_ack==1; result_vld then clears in the next cycle and the state returns to IDLE.
REQ-027 result_ack while result_vld==0 SHALL be ignored.
REQ-028 In any state other than IDLE, an in_wr with in_ctrl==IOQ_CTRL SHALL pulse skipped_pkt for one cycle, and that packet SHALL NOT be parsed.
REQ-029 Exception to REQ-028: in HOLD, if result_ack==1 and an IOQ header arrive in the same cycle, the header SHALL be skipped (pulse skipped_pkt) and the state SHALL return to IDLE.
REQ-030 Payload words after word 4 and while not in PARSE SHALL be ignored.
REQ-031 lookup_req SHALL never be asserted while lookup_ack==1 from a prior request.
REQ-032 Latency: lookup_req SHALL rise 1 cycle after the word-4 in_wr.

Reset
REQ-033 Reset SHALL force state to IDLE and clear lookup_req, result_vld, skipped_pkt, short_pkt, result_ports, all key outputs, src_port and word_cnt.
REQ-034 Reset asserted mid-transaction SHALL abandon any outstanding request.
REQ-035 After a reset during REQ, the block SHALL honour REQ-031 by staying in IDLE until a new IOQ header arrives.

Verification
REQ-036 Normal packet: IOQ header src_port=2, then words 0..4 carrying dst_mac=0x0011_2233_4455, src_mac=0x6677_8899_AABB, src_ip=0x0A000001, dst_ip=0x0A000002 -> lookup_req rises 1 cycle after word 4 with exactly those keys.
REQ-037 Result path: lookup_ack with dst_ports=8'h10 -> result_vld=1 with result_ports=8'h10, held until result_ack, then cleared the next cycle.
REQ-038 Short packet: IOQ header, then 2 payload words, then an in_ctrl=8'h01 word -> short_pkt pulses once, lookup_req stays 0, state returns to IDLE.
REQ-039 Overlap: second IOQ header while in REQ -> skipped_pkt pulses once and the first lookup completes unaffected; lookup_ack held high 5 cycles -> no new lookup_req until it drops.
REQ-040 Reset during WAIT_ACK_LOW -> all outputs 0 next cycle; a subsequent packet parses and requests normally.

Source files
------------

// File: rtl/as_lut_lookup_req.sv
// Snoops the datapath for the IOQ header and the Ethernet/IP key fields, issues one LUT
// lookup per packet and holds the returned port bitmap until the consumer accepts it.
module as_lut_lookup_req #(
    parameter int unsigned NUM_OUTPUT_QUEUES = 8,
    parameter int unsigned NUM_IQ_BITS       = 3,
    parameter logic [7:0]  IOQ_CTRL          = 8'hFF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [63:0]                  in_data,
    input  logic [7:0]                   in_ctrl,
    input  logic                         in_wr,
    output logic [47:0]                  dst_mac,
    output logic [47:0]                  src_mac,
    output logic [31:0]                  src_ip,
    output logic [31:0]                  dst_ip,
    output logic [NUM_IQ_BITS-1:0]       src_port,
    output logic                         lookup_req,
    input  logic                         lookup_ack,
    input  logic [NUM_OUTPUT_QUEUES-1:0] dst_ports,
    output logic [NUM_OUTPUT_QUEUES-1:0] result_ports,
    output logic                         result_vld,
    input  logic                         result_ack,
    output logic                         skipped_pkt,
    output logic                         short_pkt
);

    typedef enum logic [2:0] {StIdle, StParse, StReq, StWaitAckLow, StHold} state_e;

    state_e                         state_q, state_d;
    logic [2:0]                     word_cnt_q, word_cnt_d;
    logic [47:0]                    dst_mac_q, dst_mac_d, src_mac_q, src_mac_d;
    logic [31:0]                    src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
    logic [NUM_IQ_BITS-1:0]         src_port_q, src_port_d;
    logic                           lookup_req_q, lookup_req_d;
    logic [NUM_OUTPUT_QUEUES-1:0]   result_ports_q, result_ports_d;
    logic                           result_vld_q, result_vld_d;
    logic                           skipped_q, skipped_d, short_q, short_d;

    logic is_hdr, is_pay;
    assign is_hdr = in_wr && (in_ctrl == IOQ_CTRL);
    assign is_pay = in_wr && (in_ctrl == 8'h00);

    always_comb begin
        state_d        = state_q;
        word_cnt_d     = word_cnt_q;
        dst_mac_d      = dst_mac_q;
        src_mac_d      = src_mac_q;
        src_ip_d       = src_ip_q;
        dst_ip_d       = dst_ip_q;
        src_port_d     = src_port_q;
        lookup_req_d   = lookup_req_q;
        result_ports_d = result_ports_q;
        result_vld_d   = result_vld_q;
        skipped_d      = 1'b0;
        short_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (is_hdr) begin
                    src_port_d = in_data[16 +: NUM_IQ_BITS];
                    word_cnt_d = 3'd0;
                    state_d    = StParse;
                end
            end
            StParse: begin
                if (is_hdr) begin
                    skipped_d = 1'b1;
                end else if (is_pay) begin
                    case (word_cnt_q)
                        3'd0: begin
                            dst_mac_d        = in_data[63:16];
                            src_mac_d[47:32] = in_data[15:0];
                        end
                        3'd1: src_mac_d[31:0] = in_data[63:32];
                        3'd3: begin
                            src_ip_d        = in_data[47:16];
                            dst_ip_d[31:16] = in_data[15:0];
                        end
                        3'd4: begin
                            dst_ip_d[15:0] = in_data[63:48];
                            state_d        = StReq;
                            // A stale ack from an abandoned request must drop before we ask.
                            lookup_req_d   = !lookup_ack;
                        end
                        default: ;
                    endcase
                    if (word_cnt_q != 3'd7) begin
                        word_cnt_d = word_cnt_q + 3'd1;
                    end
                end else if (in_wr) begin
                    short_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StReq: begin
                skipped_d = is_hdr;
                if (lookup_req_q && lookup_ack) begin
                    result_ports_d = dst_ports;
                    lookup_req_d   = 1'b0;
                    state_d        = StWaitAckLow;
                end else if (!lookup_req_q && !lookup_ack) begin
                    lookup_req_d = 1'b1;
                end
            end
            StWaitAckLow: begin
                skipped_d = is_hdr;
                if (!lookup_ack) begin
                    result_vld_d = 1'b1;
                    state_d      = StHold;
                end
            end
            StHold: begin
                skipped_d = is_hdr;
                if (result_ack) begin
                    result_vld_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            word_cnt_q     <= 3'd0;
            dst_mac_q      <= '0;
            src_mac_q      <= '0;
            src_ip_q       <= '0;
            dst_ip_q       <= '0;
            src_port_q     <= '0;
            lookup_req_q   <= 1'b0;
            result_ports_q <= '0;
            result_vld_q   <= 1'b0;
            skipped_q      <= 1'b0;
            short_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_cnt_q     <= word_cnt_d;
            dst_mac_q      <= dst_mac_d;
            src_mac_q      <= src_mac_d;
            src_ip_q       <= src_ip_d;
            dst_ip_q       <= dst_ip_d;
            src_port_q     <= src_port_d;
            lookup_req_q   <= lookup_req_d;
            result_ports_q <= result_ports_d;
            result_vld_q   <= result_vld_d;
            skipped_q      <= skipped_d;
            short_q        <= short_d;
        end
    end

    assign dst_mac      = dst_mac_q;
    assign src_mac      = src_mac_q;
    assign src_ip       = src_ip_q;
    assign dst_ip       = dst_ip_q;
    assign src_port     = src_port_q;
    assign lookup_req   = lookup_req_q;
    assign result_ports = result_ports_q;
    assign result_vld   = result_vld_q;
    assign skipped_pkt  = skipped_q;
    assign short_pkt    = short_q;

endmodule

// File: tb/tb_as_lut_lookup_req.sv
// Directed bench for as_lut_lookup_req: normal lookup, result handshake, short packet,
// overlapping header with a long ack, and reset in the middle of a transaction.
module tb_as_lut_lookup_req;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic [47:0] dst_mac, src_mac;
    logic [31:0] src_ip, dst_ip;
    logic [2:0]  src_port;
    logic        lookup_req, lookup_ack;
    logic [7:0]  dst_ports, result_ports;
    logic        result_vld, result_ack, skipped_pkt, short_pkt;

    int total = 0;
    int bad   = 0;

    as_lut_lookup_req dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_ctrl      (in_ctrl),
        .in_wr        (in_wr),
        .dst_mac      (dst_mac),
        .src_mac      (src_mac),
        .src_ip       (src_ip),
        .dst_ip       (dst_ip),
        .src_port     (src_port),
        .lookup_req   (lookup_req),
        .lookup_ack   (lookup_ack),
        .dst_ports    (dst_ports),
        .result_ports (result_ports),
        .result_vld   (result_vld),
        .result_ack   (result_ack),
        .skipped_pkt  (skipped_pkt),
        .short_pkt    (short_pkt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] ctrl, input logic [63:0] data);
        in_wr   = 1'b1;
        in_ctrl = ctrl;
        in_data = data;
        tick();
        in_wr   = 1'b0;
        in_ctrl = 8'h00;
        in_data = '0;
    endtask

    // Header plus words 0..3; word 4 is left to the caller so it can check the latency edge.
    task automatic send_head(input logic [2:0] port, input logic [47:0] dm, input logic [47:0] sm,
                             input logic [31:0] sip, input logic [31:0] dip);
        send(8'hFF, {45'h0, port, 16'h0});
        send(8'h00, {dm, sm[47:32]});
        send(8'h00, {sm[31:0], 32'h0});
        send(8'h00, 64'hDEAD_BEEF_DEAD_BEEF);
        send(8'h00, {16'h0, sip, dip[31:16]});
    endtask

    task automatic check_keys(input string tag, input logic [2:0] port, input logic [47:0] dm,
                              input logic [47:0] sm, input logic [31:0] sip,
                              input logic [31:0] dip);
        check({tag, "_dst_mac"}, {16'h0, dst_mac}, {16'h0, dm});
        check({tag, "_src_mac"}, {16'h0, src_mac}, {16'h0, sm});
        check({tag, "_src_ip"}, {32'h0, src_ip}, {32'h0, sip});
        check({tag, "_dst_ip"}, {32'h0, dst_ip}, {32'h0, dip});
        check({tag, "_src_port"}, {61'h0, src_port}, {61'h0, port});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {49'h0, lookup_req, result_vld, skipped_pkt, short_pkt,
              result_ports, src_port}, 64'h0);
        check({tag, "_macs"}, {dst_mac | src_mac}, 64'h0);
        check({tag, "_ips"}, {src_ip, dst_ip}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_data = '0; in_ctrl = '0; in_wr = 1'b0;
        lookup_ack = 1'b0; dst_ports = '0; result_ack = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Normal packet
        send_head(3'd2, 48'h0011_2233_4455, 48'h6677_8899_AABB, 32'h0A00_0001, 32'h0A00_0002);
        check("req_before_w4", {63'h0, lookup_req}, 64'h0);
        send(8'h00, 64'h0002_0000_0000_0000);
        check("req_after_w4", {63'h0, lookup_req}, 64'h1);
        check_keys("norm", 3'd2, 48'h0011_2233_4455, 48'h6677_8899_AABB,
                   32'h0A00_0001, 32'h0A00_0002);
        result_ack = 1'b1;   // no result pending, must be ignored
        tick();
        result_ack = 1'b0;
        check("req_held", {63'h0, lookup_req}, 64'h1);
        check("vld_ignored_ack", {63'h0, result_vld}, 64'h0);

        // Result path
        lookup_ack = 1'b1; dst_ports = 8'h10;
        tick();
        lookup_ack = 1'b0; dst_ports = 8'h00;
        check("req_drop", {63'h0, lookup_req}, 64'h0);
        check("vld_wait", {63'h0, result_vld}, 64'h0);
        tick();
        check("vld_hold", {63'h0, result_vld}, 64'h1);
        check("res_ports", {56'h0, result_ports}, 64'h10);
        tick(); tick();
        check("vld_still", {63'h0, result_vld}, 64'h1);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        check("vld_clear", {63'h0, result_vld}, 64'h0);

        // Short packet
        send(8'hFF, 64'h0000_0000_0005_0000);
        send(8'h00, 64'h1111_1111_1111_1111);
        send(8'h00, 64'h2222_2222_2222_2222);
        send(8'h01, 64'h3333_3333_3333_3333);
        check("short_pulse", {62'h0, short_pkt, lookup_req}, 64'h2);
        tick();
        check("short_once", {62'h0, short_pkt, lookup_req}, 64'h0);
        send(8'h00, 64'h4444_4444_4444_4444);  // stray payload in IDLE, ignored
        tick();
        check("short_no_req", {63'h0, lookup_req}, 64'h0);

        // Overlap: second header while in REQ, then a long ack
        send_head(3'd6, 48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 32'hC0A8_0101, 32'hC0A8_0102);
        send(8'h00, 64'h0102_0000_0000_0000);
        check("ovl_req", {63'h0, lookup_req}, 64'h1);
        send(8'hFF, 64'h0000_0000_0001_0000);
        check("ovl_skip", {63'h0, skipped_pkt}, 64'h1);
        send(8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
        check("ovl_skip_once", {63'h0, skipped_pkt}, 64'h0);
        check_keys("ovl", 3'd6, 48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6,
                   32'hC0A8_0101, 32'hC0A8_0102);
        lookup_ack = 1'b1; dst_ports = 8'h05;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("ovl_ack_hi%0d", i), {62'h0, lookup_req, result_vld}, 64'h0);
        end
        lookup_ack = 1'b0; dst_ports = 8'h00;
        tick();
        check("ovl_vld", {55'h0, result_vld, result_ports}, {55'h0, 1'b1, 8'h05});
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        check("ovl_vld_clr", {63'h0, result_vld}, 64'h0);

        // Reset during WAIT_ACK_LOW
        send_head(3'd1, 48'h0102_0304_0506, 48'h0708_090A_0B0C, 32'h0101_0101, 32'h0202_0202);
        send(8'h00, 64'h0202_0000_0000_0000);
        lookup_ack = 1'b1; dst_ports = 8'h3C;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; lookup_ack = 1'b0; dst_ports = 8'h00;
        check_all_zero("rst_wait");
        send_head(3'd4, 48'h0011_2233_4455, 48'h6677_8899_AABB, 32'h0A00_0001, 32'h0A00_0002);
        send(8'h00, 64'h0002_0000_0000_0000);
        check("post_rst_req", {63'h0, lookup_req}, 64'h1);
        check_keys("post_rst", 3'd4, 48'h0011_2233_4455, 48'h6677_8899_AABB,
                   32'h0A00_0001, 32'h0A00_0002);

        // Reset during REQ with a stale ack still high: no request until it drops
        lookup_ack = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_req_clear", {63'h0, lookup_req}, 64'h0);
        send_head(3'd3, 48'h1, 48'h2, 32'h3, 32'h4);
        send(8'h00, 64'h0004_0000_0000_0000);
        check("stale_ack_no_req", {63'h0, lookup_req}, 64'h0);
        tick();
        check("stale_ack_still", {63'h0, lookup_req}, 64'h0);
        lookup_ack = 1'b0;
        tick();
        check("stale_ack_req", {63'h0, lookup_req}, 64'h1);
        check("stale_ack_vld", {63'h0, result_vld}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
